// File: rtl/kinase_ctrl_pkg.sv
// Shared types and constants for the kinase valve sequencer.
// Holds the group widths, the sequencer state enum, the registered command
// payload and the pump phase pattern table.
package kinase_ctrl_pkg;

    localparam int unsigned CTRL_A_W    = 13;
    localparam int unsigned CTRL_S_W    = 4;
    localparam int unsigned PUMP_A_W    = 3;
    localparam int unsigned PUMP_B_W    = 2;
    localparam int unsigned PUMP_CYC_W  = 8;
    localparam int unsigned PHASE_LEN_W = 16;
    localparam int unsigned PHASE_IDX_W = 2;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PUMP   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [CTRL_A_W-1:0]   ctrl_a;
        logic [CTRL_S_W-1:0]   ctrl_s;
        logic                  pump_sel;
        logic [PUMP_CYC_W-1:0] pump_cycles;
    } seq_cmd_t;

    // Phases per full pump cycle: pump A has 3, pump B has 2.
    function automatic logic [PHASE_IDX_W-1:0] phase_count(input logic sel);
        return sel ? PHASE_IDX_W'(2) : PHASE_IDX_W'(3);
    endfunction

    // Valve pattern for a phase; pump B patterns sit in the low two bits.
    function automatic logic [PUMP_A_W-1:0] phase_pattern(input logic sel,
                                                          input logic [PHASE_IDX_W-1:0] idx);
        logic [PUMP_A_W-1:0] pat;
        pat = '0;
        if (!sel) begin
            case (idx)
                2'd0:    pat = 3'b100;
                2'd1:    pat = 3'b010;
                2'd2:    pat = 3'b001;
                default: pat = 3'b000;
            endcase
        end else begin
            case (idx)
                2'd0:    pat = 3'b001;
                2'd1:    pat = 3'b010;
                default: pat = 3'b000;
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/kinase_valve_sequencer_if.sv
// Command handshake bundle for the kinase valve sequencer.
// master: drives cmd_valid and the cmd_* payload, receives cmd_ready.
// slave : the sequencer side.
interface kinase_valve_sequencer_if;
    import kinase_ctrl_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CTRL_A_W-1:0]   cmd_ctrl_a;
    logic [CTRL_S_W-1:0]   cmd_ctrl_s;
    logic                  cmd_pump_sel;
    logic [PUMP_CYC_W-1:0] cmd_pump_cycles;

    modport master (
        output cmd_valid, cmd_ctrl_a, cmd_ctrl_s, cmd_pump_sel, cmd_pump_cycles,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ctrl_a, cmd_ctrl_s, cmd_pump_sel, cmd_pump_cycles,
        output cmd_ready
    );

endinterface

// File: rtl/peristaltic_phase_gen.sv
// Peristaltic pump phase generator.
// Ports: clk, rst_n; enable (high for every PUMP cycle), sel (0 = pump A,
// 1 = pump B), phase_len (cycles per phase), cycles (full pump cycles);
// pattern (current valve pattern, 0 when disabled), last (final PUMP cycle).
// Counters restart whenever enable is low, so the first enabled cycle shows
// phase 0 with no setup latency.
module peristaltic_phase_gen
    import kinase_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   sel,
    input  logic [PHASE_LEN_W-1:0] phase_len,
    input  logic [PUMP_CYC_W-1:0]  cycles,
    output logic [PUMP_A_W-1:0]    pattern,
    output logic                   last
);

    logic [PHASE_LEN_W-1:0] r_tick;
    logic [PHASE_IDX_W-1:0] r_idx;
    logic [PUMP_CYC_W-1:0]  r_cyc;
    logic                   w_phase_end;
    logic                   w_cycle_end;

    assign w_phase_end = (r_tick == phase_len - PHASE_LEN_W'(1));
    assign w_cycle_end = w_phase_end && (r_idx == phase_count(sel) - PHASE_IDX_W'(1));

    // Separate tick/phase/cycle counters: 255 x 3 x phase_len never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
            r_idx  <= '0;
            r_cyc  <= '0;
        end else if (!enable) begin
            r_tick <= '0;
            r_idx  <= '0;
            r_cyc  <= '0;
        end else if (w_phase_end) begin
            r_tick <= '0;
            if (w_cycle_end) begin
                r_idx <= '0;
                r_cyc <= r_cyc + PUMP_CYC_W'(1);
            end else begin
                r_idx <= r_idx + PHASE_IDX_W'(1);
            end
        end else begin
            r_tick <= r_tick + PHASE_LEN_W'(1);
        end
    end

    assign pattern = enable ? phase_pattern(sel, r_idx) : '0;
    assign last    = enable && w_cycle_end && (r_cyc == cycles - PUMP_CYC_W'(1));

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Kinase valve sequencer: accepts a valve/pump command, holds the valve masks
// through a settle period and a peristaltic pump period, then vents the used
// groups for a flush period and pulses done (and aborted if cut short).
// Ports: clk, rst_n; cmd_if (slave handshake + payload); abort;
// pad_ctrl_a/s, pad_pump_a/b (valve drives); pad_flush_* (vent drives);
// busy, done, aborted (status).
module kinase_valve_sequencer
    import kinase_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned PHASE_CYC  = 8,
    parameter int unsigned FLUSH_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kinase_valve_sequencer_if.slave cmd_if,
    input  logic                  abort,
    output logic [CTRL_A_W-1:0]   pad_ctrl_a,
    output logic [CTRL_S_W-1:0]   pad_ctrl_s,
    output logic [PUMP_A_W-1:0]   pad_pump_a,
    output logic [PUMP_B_W-1:0]   pad_pump_b,
    output logic [CTRL_A_W-1:0]   pad_flush_ctrl_a,
    output logic [CTRL_S_W-1:0]   pad_flush_ctrl_s,
    output logic [PUMP_A_W-1:0]   pad_flush_pump_a,
    output logic [PUMP_B_W-1:0]   pad_flush_pump_b,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    seq_state_t          r_state;
    seq_cmd_t            r_cmd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_abort_flag;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;
    logic [CTRL_A_W-1:0] r_pad_ctrl_a;
    logic [CTRL_S_W-1:0] r_pad_ctrl_s;
    logic [CTRL_A_W-1:0] r_flush_ctrl_a;
    logic [CTRL_S_W-1:0] r_flush_ctrl_s;
    logic [PUMP_A_W-1:0] r_flush_pump_a;
    logic [PUMP_B_W-1:0] r_flush_pump_b;

    logic                w_pump_en;
    logic [PUMP_A_W-1:0] w_pattern;
    logic                w_pump_last;
    logic                w_settle_end;
    logic                w_abort_take;
    logic                w_to_flush;

    assign w_pump_en    = (r_state == ST_PUMP);
    assign w_settle_end = (r_state == ST_SETTLE) && (r_cnt == CNT_W'(SETTLE_CYC - 1));
    assign w_abort_take = abort && ((r_state == ST_SETTLE) || (r_state == ST_PUMP));
    assign w_to_flush   = w_abort_take
                       || (w_settle_end && (r_cmd.pump_cycles == '0))
                       || (w_pump_en && w_pump_last);

    peristaltic_phase_gen u_phase_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (w_pump_en),
        .sel       (r_cmd.pump_sel),
        .phase_len (PHASE_LEN_W'(PHASE_CYC)),
        .cycles    (r_cmd.pump_cycles),
        .pattern   (w_pattern),
        .last      (w_pump_last)
    );

    // Sequencer FSM; valve, vent and status outputs change on the transition edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cmd          <= '0;
            r_cnt          <= '0;
            r_abort_flag   <= 1'b0;
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_aborted      <= 1'b0;
            r_pad_ctrl_a   <= '0;
            r_pad_ctrl_s   <= '0;
            r_flush_ctrl_a <= '0;
            r_flush_ctrl_s <= '0;
            r_flush_pump_a <= '0;
            r_flush_pump_b <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (w_to_flush) begin
                r_state        <= ST_FLUSH;
                r_cnt          <= '0;
                r_pad_ctrl_a   <= '0;
                r_pad_ctrl_s   <= '0;
                r_flush_ctrl_a <= r_cmd.ctrl_a;
                r_flush_ctrl_s <= r_cmd.ctrl_s;
                r_flush_pump_a <= r_cmd.pump_sel ? '0 : '1;
                r_flush_pump_b <= r_cmd.pump_sel ? '1 : '0;
                if (w_abort_take) begin
                    r_abort_flag <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // cmd_ready is high throughout IDLE
                        if (cmd_if.cmd_valid) begin
                            r_state      <= ST_SETTLE;
                            r_cmd        <= '{ctrl_a:      cmd_if.cmd_ctrl_a,
                                              ctrl_s:      cmd_if.cmd_ctrl_s,
                                              pump_sel:    cmd_if.cmd_pump_sel,
                                              pump_cycles: cmd_if.cmd_pump_cycles};
                            r_cnt        <= '0;
                            r_abort_flag <= 1'b0;
                            r_ready      <= 1'b0;
                            r_busy       <= 1'b1;
                            r_pad_ctrl_a <= cmd_if.cmd_ctrl_a;
                            r_pad_ctrl_s <= cmd_if.cmd_ctrl_s;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_settle_end) begin
                            r_state <= ST_PUMP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_PUMP: begin
                        // duration tracked by the phase generator
                    end
                    ST_FLUSH: begin
                        if (r_cnt == CNT_W'(FLUSH_CYC - 1)) begin
                            r_state        <= ST_DONE;
                            r_flush_ctrl_a <= '0;
                            r_flush_ctrl_s <= '0;
                            r_flush_pump_a <= '0;
                            r_flush_pump_b <= '0;
                            r_done         <= 1'b1;
                            r_aborted      <= r_abort_flag;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd_if.cmd_ready = r_ready;
    assign busy             = r_busy;
    assign done             = r_done;
    assign aborted          = r_aborted;
    assign pad_ctrl_a       = r_pad_ctrl_a;
    assign pad_ctrl_s       = r_pad_ctrl_s;
    assign pad_pump_a       = r_cmd.pump_sel ? '0 : w_pattern;
    assign pad_pump_b       = r_cmd.pump_sel ? w_pattern[PUMP_B_W-1:0] : '0;
    assign pad_flush_ctrl_a = r_flush_ctrl_a;
    assign pad_flush_ctrl_s = r_flush_ctrl_s;
    assign pad_flush_pump_a = r_flush_pump_a;
    assign pad_flush_pump_b = r_flush_pump_b;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Testbench for kinase_valve_sequencer: a timeline model of each command
// (settle / pump / flush / done windows counted from acceptance) is compared
// with every DUT output on each falling edge, alongside directed scenarios
// with hand-computed latencies and a randomized command stream.
module tb_kinase_valve_sequencer;
    import kinase_ctrl_pkg::*;

    localparam int S  = 16;
    localparam int PH = 8;
    localparam int F  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        abort = 1'b0;
    logic [12:0] pad_ctrl_a, pad_flush_ctrl_a;
    logic [3:0]  pad_ctrl_s, pad_flush_ctrl_s;
    logic [2:0]  pad_pump_a, pad_flush_pump_a;
    logic [1:0]  pad_pump_b, pad_flush_pump_b;
    logic        busy, done, aborted;

    int errors = 0;
    int checks = 0;

    kinase_valve_sequencer_if cmd_if();

    kinase_valve_sequencer #(.SETTLE_CYC(S), .PHASE_CYC(PH), .FLUSH_CYC(F)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_if           (cmd_if),
        .abort            (abort),
        .pad_ctrl_a       (pad_ctrl_a),
        .pad_ctrl_s       (pad_ctrl_s),
        .pad_pump_a       (pad_pump_a),
        .pad_pump_b       (pad_pump_b),
        .pad_flush_ctrl_a (pad_flush_ctrl_a),
        .pad_flush_ctrl_s (pad_flush_ctrl_s),
        .pad_flush_pump_a (pad_flush_pump_a),
        .pad_flush_pump_b (pad_flush_pump_b),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_n counts cycles since acceptance (1 = first cycle after it).
    bit          m_active = 1'b0;
    int          m_n = 0;
    int          m_flush_at = 0;
    bit          m_abort = 1'b0;
    logic [12:0] m_a = '0;
    logic [3:0]  m_s = '0;
    bit          m_sel = 1'b0;
    int          m_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_n      = 0;
        end else if (!m_active) begin
            if (cmd_if.cmd_valid === 1'b1) begin
                m_active   = 1'b1;
                m_n        = 1;
                m_a        = cmd_if.cmd_ctrl_a;
                m_s        = cmd_if.cmd_ctrl_s;
                m_sel      = cmd_if.cmd_pump_sel;
                m_cyc      = int'(cmd_if.cmd_pump_cycles);
                m_flush_at = S + m_cyc * (m_sel ? 2 : 3) * PH + 1;
                m_abort    = 1'b0;
            end
        end else if (m_n == m_flush_at + F) begin
            m_active = 1'b0;
        end else begin
            if (abort === 1'b1 && m_n < m_flush_at) begin
                m_flush_at = m_n + 1;
                m_abort    = 1'b1;
            end
            m_n++;
        end
    end

    always @(negedge clk) begin : cmp
        logic [12:0] ea, efa;
        logic [3:0]  es, efs;
        logic [2:0]  epa, efpa;
        logic [1:0]  epb, efpb;
        logic        edone, eab;
        int          k;
        if (rst_n) begin
            ea = '0; es = '0; epa = '0; epb = '0;
            efa = '0; efs = '0; efpa = '0; efpb = '0;
            edone = 1'b0; eab = 1'b0;
            if (m_active) begin
                if (m_n < m_flush_at) begin
                    ea = m_a;
                    es = m_s;
                    if (m_n > S) begin
                        k = ((m_n - S - 1) / PH) % (m_sel ? 2 : 3);
                        if (m_sel) epb = (k == 0) ? 2'b01 : 2'b10;
                        else       epa = 3'b100 >> k;
                    end
                end else if (m_n < m_flush_at + F) begin
                    efa = m_a;
                    efs = m_s;
                    if (m_sel) efpb = 2'b11;
                    else       efpa = 3'b111;
                end else begin
                    edone = 1'b1;
                    eab   = m_abort;
                end
            end
            chk("cmd_ready", cmd_if.cmd_ready, !m_active);
            chk("busy", busy, m_active);
            chk("done", done, edone);
            chk("aborted", aborted, eab);
            chk("pad_ctrl_a", pad_ctrl_a, ea);
            chk("pad_ctrl_s", pad_ctrl_s, es);
            chk("pad_pump_a", pad_pump_a, epa);
            chk("pad_pump_b", pad_pump_b, epb);
            chk("flush_ctrl_a", pad_flush_ctrl_a, efa);
            chk("flush_ctrl_s", pad_flush_ctrl_s, efs);
            chk("flush_pump_a", pad_flush_pump_a, efpa);
            chk("flush_pump_b", pad_flush_pump_b, efpb);
        end
    end

    int   res_done, res_pump, res_flush, res_wait;
    logic res_ab;

    // Offer a command (called right after a falling edge), run it to done.
    // abort_n > 0 raises abort during that cycle after acceptance.
    task automatic run_cmd(input logic [12:0] a, input logic [3:0] s, input logic sel,
                           input logic [7:0] cyc, input int abort_n, input bit hold);
        int n;
        bit fin;
        cmd_if.cmd_ctrl_a      = a;
        cmd_if.cmd_ctrl_s      = s;
        cmd_if.cmd_pump_sel    = sel;
        cmd_if.cmd_pump_cycles = cyc;
        cmd_if.cmd_valid       = 1'b1;
        res_wait = 0; res_done = -1; res_pump = 0; res_flush = 0; res_ab = 1'b0;
        while (cmd_if.cmd_ready !== 1'b1 && res_wait < 10000) begin
            @(negedge clk);
            res_wait++;
        end
        if (cmd_if.cmd_ready !== 1'b1) begin
            chk("accept_timeout", cmd_if.cmd_ready, 1);
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        n = 0;
        fin = 1'b0;
        while (!fin && n < 10000) begin
            @(negedge clk);
            n++;
            if (!hold && n == 1) cmd_if.cmd_valid = 1'b0;
            abort = (n == abort_n);
            if ((pad_pump_a | 3'(pad_pump_b)) != 3'b000) res_pump++;
            if ((pad_flush_ctrl_a != '0) || (pad_flush_ctrl_s != '0) ||
                (pad_flush_pump_a != '0) || (pad_flush_pump_b != '0)) res_flush++;
            if (done === 1'b1) begin
                res_done = n;
                res_ab   = aborted;
                fin      = 1'b1;
            end
        end
        abort = 1'b0;
        if (!fin) chk("done_timeout", done, 1);
    endtask

    initial begin
        cmd_if.cmd_valid       = 1'b0;
        cmd_if.cmd_ctrl_a      = '0;
        cmd_if.cmd_ctrl_s      = '0;
        cmd_if.cmd_pump_sel    = 1'b0;
        cmd_if.cmd_pump_cycles = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_ctrl_a", pad_ctrl_a, 0);
        chk("rst_pump_a", pad_pump_a, 0);
        chk("rst_flush_a", pad_flush_ctrl_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_if.cmd_ready, 1);

        // Pump A, two cycles: 16 + 48 + 4 + done
        run_cmd(13'h1ABC, 4'h5, 1'b0, 8'd2, 0, 1'b0);
        chk("a2_done_lat", res_done, 69);
        chk("a2_pump_cyc", res_pump, 48);
        chk("a2_flush_cyc", res_flush, 4);
        chk("a2_aborted", res_ab, 0);
        repeat (2) @(negedge clk);

        // Pump B, zero cycles: settle straight into flush
        run_cmd(13'h0155, 4'hC, 1'b1, 8'd0, 0, 1'b0);
        chk("b0_done_lat", res_done, 21);
        chk("b0_pump_cyc", res_pump, 0);
        chk("b0_flush_cyc", res_flush, 4);

        // Abort on the 10th PUMP cycle
        run_cmd(13'h0F0F, 4'hA, 1'b0, 8'd3, S + 10, 1'b0);
        chk("ab_done_lat", res_done, S + 10 + F + 1);
        chk("ab_pump_cyc", res_pump, 10);
        chk("ab_flush_cyc", res_flush, 4);
        chk("ab_aborted", res_ab, 1);
        @(negedge clk);

        // cmd_valid held through a whole command
        run_cmd(13'h1234, 4'h3, 1'b1, 8'd1, 0, 1'b1);
        chk("hold1_done_lat", res_done, S + 16 + F + 1);
        run_cmd(13'h1234, 4'h3, 1'b1, 8'd1, 0, 1'b0);
        chk("hold2_wait", res_wait, 1);
        chk("hold2_done_lat", res_done, S + 16 + F + 1);
        repeat (3) @(negedge clk);

        // Reset in the middle of PUMP
        cmd_if.cmd_ctrl_a      = 13'h1FFF;
        cmd_if.cmd_ctrl_s      = 4'hF;
        cmd_if.cmd_pump_sel    = 1'b0;
        cmd_if.cmd_pump_cycles = 8'd4;
        cmd_if.cmd_valid       = 1'b1;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (S + 4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl_a", pad_ctrl_a, 0);
        chk("mid_rst_ctrl_s", pad_ctrl_s, 0);
        chk("mid_rst_pump_a", pad_pump_a, 0);
        chk("mid_rst_flush_a", pad_flush_ctrl_a, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", cmd_if.cmd_ready, 1);
        chk("rel_busy", busy, 0);
        repeat (10) @(negedge clk);

        // Randomized command stream
        for (int it = 0; it < 30; it++) begin
            int gap;
            int an;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                abort = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            abort = 1'b0;
            an = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 110)) : 0;
            run_cmd(13'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 3)), an, ($urandom_range(0, 3) == 0));
        end
        cmd_if.cmd_valid = 1'b0;
        repeat (120) @(negedge clk);

        // Longest pump run: 255 x 3 x 8 cycles
        run_cmd(13'h0AAA, 4'h9, 1'b0, 8'd255, 0, 1'b0);
        chk("long_pump_cyc", res_pump, 6120);
        chk("long_done_lat", res_done, S + 6120 + F + 1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kinase_valve_sequencer.md
KINASE_VALVE_SEQUENCER -- requirements
Module: kinase_valve_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16, cycles valves are held before pumping starts (minimum 1).
REQ-002 SHALL have parameter PHASE_CYC, default 8, cycles each pump phase is held (minimum 1).
REQ-003 SHALL have parameter FLUSH_CYC, default 4, cycles flush outputs are held (minimum 1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-008 cmd_ctrl_a  input  13  valve mask for the pad_ctrl_a group.
REQ-009 cmd_ctrl_s  input  4  valve mask for the pad_ctrl_s group.
REQ-010 cmd_pump_sel  input  1  0 = pump A (3-valve), 1 = pump B (2-valve).
REQ-011 cmd_pump_cycles  input  8  number of full pump cycles; 0 = no pumping.
REQ-012 abort  input  1  terminate the current command via flush.
REQ-013 pad_ctrl_a / pad_ctrl_s / pad_pump_a / pad_pump_b  output  13/4/3/2  valve drives, 1 = actuated.
REQ-014 pad_flush_ctrl_a / pad_flush_ctrl_s / pad_flush_pump_a / pad_flush_pump_b  output  13/4/3/2  vent drives, 1 = venting.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on command completion.
REQ-017 aborted  output  1  one-cycle pulse, coincident with done, when the command ended by abort.

Function
REQ-018 States SHALL be IDLE, SETTLE, PUMP, FLUSH, DONE.
REQ-019 cmd_ready SHALL equal (state==IDLE); a command is accepted on cmd_valid&&cmd_ready, and all cmd_* fields are registered at acceptance.
REQ-020 IDLE->SETTLE on acceptance; pad_ctrl_a/pad_ctrl_s SHALL show the registered masks from the cycle after acceptance through the end of PUMP.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to PUMP when pump_cycles>0, else directly to FLUSH.
REQ-022 Pump A SHALL step through phases 3'b100, 3'b010, 3'b001 (one cycle = 3 phases); pump B through 2'b01, 2'b10 (one cycle = 2 phases); each phase held PHASE_CYC cycles; the unselected pump group SHALL stay 0.
REQ-023 PUMP SHALL last exactly pump_cycles*phases*PHASE_CYC cycles (255*3*PHASE_CYC max, so the counter must not wrap), then go to FLUSH.
REQ-024 In FLUSH, all pad_ctrl_*/pad_pump_* SHALL be 0 and each pad_flush_* SHALL equal the registered mask of its group (pump group flushed: all-ones for the selected pump, 0 for the other); duration exactly FLUSH_CYC cycles, then DONE.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE; cmd_ready is 0 during DONE.
REQ-026 abort in SETTLE or PUMP SHALL move to FLUSH the next cycle and latch the aborted flag; abort in IDLE, FLUSH or DONE SHALL be ignored.
REQ-027 Outside FLUSH, all pad_flush_* SHALL be 0; pad_ctrl_* and pad_flush_* of the same bit SHALL never be 1 simultaneously.
REQ-028 A cmd_valid held through a busy period SHALL be accepted in the first IDLE cycle after DONE.

Reset
REQ-029 rst_n low SHALL force IDLE immediately; all pad_* outputs, busy, done and aborted SHALL be 0, cmd_ready SHALL be 1 after release, and counters/registers SHALL clear.
REQ-030 Reset mid-command SHALL drop the command with no flush and no done pulse.

Structure
REQ-031 The state enum, phase patterns and group widths (13, 4, 3, 2) SHALL live in a shared package kinase_ctrl_pkg.
REQ-032 The phase generator SHALL be a sub-module peristaltic_phase_gen (enable, sel, phase_len, cycles -> pattern, last).

Verification
REQ-033 ctrl_a=0x1ABC, ctrl_s=0x5, pump A, cycles=2, defaults -> valves set from cycle 1 after acceptance; 16 SETTLE cycles; 48 PUMP cycles of patterns 100/010/001; 4 cycles flush_ctrl_a=0x1ABC, flush_s=0x5, flush_pump_a=3'b111; done pulse.
REQ-034 pump B, cycles=0 -> SETTLE 16 cycles, then FLUSH directly, pad_pump_b stays 00 throughout, done after 21 cycles.
REQ-035 abort on PUMP cycle 10 -> FLUSH next cycle, pump outputs 0, done and aborted pulse together after 4 FLUSH cycles.
REQ-036 cmd_valid held high through a whole command -> second command accepted exactly one cycle after done; no command lost or duplicated.
REQ-037 rst_n asserted mid-PUMP -> all outputs 0 asynchronously, no done pulse; cmd_ready=1 on first clock after release.
REQ-038 cycles=255, pump A, PHASE_CYC=8 -> PUMP lasts exactly 6120 cycles, with no counter wrap.
